// File: rtl/mac_acc_pkg.sv
// mac_acc_pkg: shared types and width helpers for the streaming MAC/accumulator.
//   clog2   - ceiling log2 for elaboration-time width math
//   calc_pw - per-lane product width: unsigned pixel (zero-extended) times signed weight
//   calc_sw - adder-tree output width: product width plus one bit per tree level
//   tag_t   - per-beat sideband carried alongside the data through every stage
package mac_acc_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned calc_pw(input int unsigned dw, input int unsigned ww);
    return dw + ww + 1;
  endfunction

  function automatic int unsigned calc_sw(input int unsigned dw, input int unsigned ww,
                                          input int unsigned lanes);
    return calc_pw(dw, ww) + clog2(lanes);
  endfunction

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic relu;
  } tag_t;

  typedef enum logic {StIdle, StRun} cnt_state_e;

endpackage

// File: rtl/mac_acc_tree.sv
// mac_acc_tree: registered reduction of LANES signed products into one sum.
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset, clears the sum register
//   en_i   - advance enable; the register holds when low
//   prod_i - LANES signed products, lane i at [i*PW +: PW]
//   sum_o  - registered signed sum, PW + clog2(LANES) bits (cannot overflow)
module mac_acc_tree
  import mac_acc_pkg::*;
#(
  parameter int unsigned LANES = 16,
  parameter int unsigned PW    = 17
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 en_i,
  input  logic [LANES*PW-1:0]                  prod_i,
  output logic signed [PW+clog2(LANES)-1:0]    sum_o
);

  localparam int unsigned SW = PW + clog2(LANES);

  logic signed [SW-1:0] sum_d, sum_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + SW'($signed(prod_i[i*PW +: PW]));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/mac_acc_stream.sv
// mac_acc_stream: pipelined LANES-wide dot product accumulated over (cfg_len+1) beats,
// seeded with a signed bias, with saturation, optional ReLU and a valid/ready result port.
//   clk_i, rst_i            - clock and synchronous active-high reset
//   in_valid_i, in_ready_o  - beat handshake
//   p_i, w_i                - unsigned pixels / signed weights, lane i at [i*DW]/[i*WW]
//   b_i, cfg_len_i, cfg_relu_i - per-neuron bias, beats-minus-one, ReLU; taken on first beat
//   out_valid_o, out_ready_i - result handshake
//   dout_o, out_sat_o       - signed result and sticky saturation flag for that neuron
module mac_acc_stream
  import mac_acc_pkg::*;
#(
  parameter int unsigned LANES = 16,
  parameter int unsigned DW    = 8,
  parameter int unsigned WW    = 8,
  parameter int unsigned BW    = 8,
  parameter int unsigned ACCW  = 22,
  parameter int unsigned LENW  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [LANES*DW-1:0]      p_i,
  input  logic [LANES*WW-1:0]      w_i,
  input  logic [BW-1:0]            b_i,
  input  logic [LENW-1:0]          cfg_len_i,
  input  logic                     cfg_relu_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [ACCW-1:0]   dout_o,
  output logic                     out_sat_o
);

  localparam int unsigned PW = calc_pw(DW, WW);
  localparam int unsigned SW = calc_sw(DW, WW, LANES);
  localparam logic signed [ACCW-1:0] AccMax = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] AccMin = {1'b1, {(ACCW-1){1'b0}}};

  logic en, beat_acc;
  logic out_valid_q;

  // Single global advance: the whole pipe freezes while a result waits downstream.
  assign en         = !out_valid_q || out_ready_i;
  assign in_ready_o = en;
  assign beat_acc   = in_valid_i && en;

  // Beat counter / framing
  cnt_state_e      state_q, state_d;
  logic [LENW-1:0] cnt_q, cnt_d, len_q, len_d;
  logic            relu_q, relu_d;
  tag_t            tag_in;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    relu_d       = relu_q;
    tag_in       = '0;
    tag_in.valid = beat_acc;
    unique case (state_q)
      StIdle: begin
        tag_in.first = 1'b1;
        tag_in.last  = (cfg_len_i == '0);
        tag_in.relu  = cfg_relu_i;
        if (beat_acc && (cfg_len_i != '0)) begin
          state_d = StRun;
          cnt_d   = {{(LENW-1){1'b0}}, 1'b1};
          len_d   = cfg_len_i;
          relu_d  = cfg_relu_i;
        end
      end
      StRun: begin
        tag_in.last = (cnt_q == len_q);
        tag_in.relu = relu_q;
        if (beat_acc) begin
          if (tag_in.last) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // S1: per-lane products
  logic [LANES*PW-1:0]    prod_d, prod_q;
  tag_t                   tag1_q, tag2_q, tag3_q;
  // Bias rides with the beat so back-to-back neurons never see each other's bias.
  logic signed [BW-1:0]   bias1_q, bias2_q;

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i*PW +: PW] = PW'($signed({1'b0, p_i[i*DW +: DW]})) * PW'($signed(w_i[i*WW +: WW]));
    end
  end

  // S2: reduction
  logic signed [SW-1:0] sum_q;

  mac_acc_tree #(
    .LANES (LANES),
    .PW    (PW)
  ) u_tree (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en),
    .prod_i (prod_q),
    .sum_o  (sum_q)
  );

  // S3: saturating accumulate, one guard bit to detect overflow
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   sat_q, sat_d;
  logic signed [ACCW:0]   acc_base, acc_full;
  logic                   ovf;

  always_comb begin
    acc_base = tag2_q.first ? (ACCW+1)'(bias2_q) : (ACCW+1)'(acc_q);
    acc_full = acc_base + (ACCW+1)'(sum_q);
    ovf      = acc_full[ACCW] != acc_full[ACCW-1];
    acc_d    = acc_q;
    sat_d    = sat_q;
    if (tag2_q.valid) begin
      if (ovf) begin
        acc_d = acc_full[ACCW] ? AccMin : AccMax;
      end else begin
        acc_d = acc_full[ACCW-1:0];
      end
      sat_d = (tag2_q.first ? 1'b0 : sat_q) | ovf;
    end
  end

  // Output register
  logic signed [ACCW-1:0] dout_q;
  logic                   out_sat_q;
  logic                   load_out;

  assign load_out = tag3_q.valid && tag3_q.last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      relu_q      <= 1'b0;
      prod_q      <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      tag3_q      <= '0;
      bias1_q     <= '0;
      bias2_q     <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_sat_q   <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      relu_q      <= relu_d;
      prod_q      <= prod_d;
      tag1_q      <= tag_in;
      bias1_q     <= b_i;
      tag2_q      <= tag1_q;
      bias2_q     <= bias1_q;
      tag3_q      <= tag2_q;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      // With en high any held result is either absent or being taken this cycle.
      out_valid_q <= load_out;
      if (load_out) begin
        dout_q    <= (tag3_q.relu && acc_q[ACCW-1]) ? '0 : acc_q;
        out_sat_q <= sat_q;
      end
    end
  end

  logic unused_tag3_first;
  assign unused_tag3_first = tag3_q.first;

  assign out_valid_o = out_valid_q;
  assign dout_o      = dout_q;
  assign out_sat_o   = out_sat_q;

endmodule
